// File: rtl/index_decoder_pkg.sv
// Shared sizing for the sparse index decoder.
// Holds the lane counts, index range, tile and filter dimensions, and the
// element types that the top, the sub-decoders and the interface all use.
package index_decoder_pkg;

   localparam int I          = 4;
   localparam int F          = 4;
   localparam int MAX_INDEX  = 16;
   localparam int MAX_NUM_HT = 32;
   localparam int MAX_NUM_WT = 32;
   localparam int MAX_SIZE_R = 11;
   localparam int MAX_SIZE_S = 11;
   localparam int KC         = 8;

   localparam int IDX_W     = $clog2(MAX_INDEX);
   localparam int IN_SIDE_W = $clog2(MAX_NUM_HT) + 1;
   localparam int IN_ROW_W  = $clog2(MAX_NUM_HT) + 1;
   localparam int IN_COL_W  = $clog2(MAX_NUM_WT) + 1;
   localparam int F_SIZE_W  = $clog2(MAX_SIZE_R * MAX_SIZE_S) + 1;
   localparam int F_SIDE_W  = $clog2(MAX_SIZE_R) + 1;
   localparam int F_ROW_W   = $clog2(MAX_SIZE_S) + 1;
   localparam int F_COL_W   = $clog2(MAX_SIZE_R) + 1;
   localparam int K_W       = $clog2(KC) + 1;

   // Running position accumulators; wide enough for long input streams.
   localparam int POS_W  = 16;
   // Group counter: the stored value saturates at KC, one vector adds at most F.
   localparam int KCNT_W = $clog2(KC + F + 1) + 1;

   typedef logic [POS_W-1:0]           pos_t;
   typedef logic [KCNT_W-1:0]          kcnt_t;
   typedef logic signed [IN_ROW_W-1:0] in_row_t;
   typedef logic signed [IN_COL_W-1:0] in_col_t;
   typedef logic signed [F_ROW_W-1:0]  f_row_t;
   typedef logic signed [F_COL_W-1:0]  f_col_t;

   // Once a lane is past the last filter of the group it stays invalid, so
   // the stored counter never needs to exceed KC.
   function automatic kcnt_t k_sat(input kcnt_t k);
      return (k > kcnt_t'(KC)) ? kcnt_t'(KC) : k;
   endfunction

endpackage

// File: rtl/index_decoder_if.sv
// Bundle of all decoder data/control signals.
// slave : used by index_decoder (controls and index vectors in, positions out)
// master: used by whoever drives the decoder
interface index_decoder_if;
   import index_decoder_pkg::*;

   logic                        stall;
   logic                        next_a;
   logic                        decode_restart;
   logic                        first_Ex_state_cycle;
   logic [I-1:0][IDX_W-1:0]     input_index_vector;
   logic [IN_SIDE_W-1:0]        input_side_length;
   in_row_t [I-1:0]             in_row_num;
   in_col_t [I-1:0]             in_col_num;
   logic [F-1:0][IDX_W-1:0]     filter_index_vector;
   logic [F_SIZE_W-1:0]         each_filter_size;
   logic [F_SIDE_W-1:0]         filter_side_length;
   logic                        Layer_change_flag;
   logic                        K_changing;
   f_row_t [F-1:0]              f_row_num;
   f_col_t [F-1:0]              f_col_num;
   logic [F-1:0][K_W-1:0]       k_num;
   logic [F-1:0]                res_rdy;

   modport slave (
      input  stall, next_a, decode_restart, first_Ex_state_cycle,
             input_index_vector, input_side_length,
             filter_index_vector, each_filter_size, filter_side_length,
             Layer_change_flag, K_changing,
      output in_row_num, in_col_num, f_row_num, f_col_num, k_num, res_rdy
   );

   modport master (
      output stall, next_a, decode_restart, first_Ex_state_cycle,
             input_index_vector, input_side_length,
             filter_index_vector, each_filter_size, filter_side_length,
             Layer_change_flag, K_changing,
      input  in_row_num, in_col_num, f_row_num, f_col_num, k_num, res_rdy
   );

endinterface

// File: rtl/index_decoder_filter.sv
// Filter-weight index decoder.
// Decodes F zero-run counts every unstalled cycle into (row, col, k) within a
// group of KC filters of R*S weights each.
// clk, rst, stall               : clock, sync reset, freeze
// restart                       : decode from (0, k0) and clear fb/kb
// layer_change                  : force res_rdy low for this decode
// index_vector                  : zero-run counts
// filter_size, side_length      : R*S and filter side
// row_num, col_num, k_num       : registered per-lane position and filter index
// res_rdy                       : per-lane valid (k still inside the group)
module index_decoder_filter import index_decoder_pkg::*; (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    restart,
   input  logic                    layer_change,
   input  logic [F-1:0][IDX_W-1:0] index_vector,
   input  logic [F_SIZE_W-1:0]     filter_size,
   input  logic [F_SIDE_W-1:0]     side_length,
   output f_row_t [F-1:0]          row_num,
   output f_col_t [F-1:0]          col_num,
   output logic [F-1:0][K_W-1:0]   k_num,
   output logic [F-1:0]            res_rdy
);

   pos_t   fb;
   kcnt_t  kb;
   pos_t   pos   [F];
   kcnt_t  kc    [F];
   f_row_t row_d [F];
   f_col_t col_d [F];

   // Crossing the end of a filter wraps the position once and moves this
   // lane, and every later lane through the running k, to the next filter.
   always_comb begin : decode
      pos_t  p;
      kcnt_t k;
      p = restart ? pos_t'(0) : fb;
      k = restart ? kcnt_t'(0) : kb;
      for (int n = 0; n < F; n++) begin
         p = p + pos_t'(index_vector[n]) + ((n == 0) ? pos_t'(0) : pos_t'(1));
         if (p >= pos_t'(filter_size)) begin
            p = p - pos_t'(filter_size);
            k = k + kcnt_t'(1);
         end
         pos[n] = p;
         kc[n]  = k;
      end
   end

   for (genvar g = 0; g < F; g++) begin : g_lane
      pos_divmod #(
         .POS_W (POS_W),
         .SIDE_W(F_SIDE_W),
         .Q_W   (F_ROW_W),
         .R_W   (F_COL_W)
      ) u_divmod (
         .pos (pos[g]),
         .side(side_length),
         .quo (row_d[g]),
         .rem (col_d[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fb      <= '0;
         kb      <= '0;
         row_num <= '0;
         col_num <= '0;
         k_num   <= '0;
         res_rdy <= '0;
      end else if (!stall) begin
         for (int n = 0; n < F; n++) begin
            row_num[n] <= row_d[n];
            col_num[n] <= col_d[n];
            k_num[n]   <= K_W'(k_sat(kc[n]));
            res_rdy[n] <= !layer_change && (kc[n] < kcnt_t'(KC));
         end
         // A restart both decodes this vector from zero and leaves the
         // stream base at zero for the following vector.
         if (restart) begin
            fb <= '0;
            kb <= '0;
         end else begin
            fb <= pos[F-1] + pos_t'(1);
            kb <= k_sat(kc[F-1]);
         end
      end
   end

endmodule

// File: rtl/index_decoder_input.sv
// Input-activation index decoder.
// Turns I zero-run counts into I (row, col) positions in the input tile.
// clk, rst, stall                  : clock, sync reset, freeze
// next_a                           : decode index_vector and advance base
// decode_restart                   : base <= 0, outputs hold
// first_Ex_state_cycle             : decode from base 0 instead of stored base
// index_vector, side_length        : zero-run counts, tile side
// row_num, col_num                 : registered per-lane positions
module index_decoder_input import index_decoder_pkg::*; (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    next_a,
   input  logic                    decode_restart,
   input  logic                    first_Ex_state_cycle,
   input  logic [I-1:0][IDX_W-1:0] index_vector,
   input  logic [IN_SIDE_W-1:0]    side_length,
   output in_row_t [I-1:0]         row_num,
   output in_col_t [I-1:0]         col_num
);

   pos_t    base;
   pos_t    pos   [I];
   in_row_t row_d [I];
   in_col_t col_d [I];

   // Each nonzero sits after its run of zeros, one slot past the previous nonzero.
   always_comb begin
      pos[0] = (first_Ex_state_cycle ? pos_t'(0) : base) + pos_t'(index_vector[0]);
      for (int n = 1; n < I; n++) begin
         pos[n] = pos[n-1] + pos_t'(index_vector[n]) + pos_t'(1);
      end
   end

   for (genvar g = 0; g < I; g++) begin : g_lane
      pos_divmod #(
         .POS_W (POS_W),
         .SIDE_W(IN_SIDE_W),
         .Q_W   (IN_ROW_W),
         .R_W   (IN_COL_W)
      ) u_divmod (
         .pos (pos[g]),
         .side(side_length),
         .quo (row_d[g]),
         .rem (col_d[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base    <= '0;
         row_num <= '0;
         col_num <= '0;
      end else if (!stall) begin
         if (decode_restart) begin
            base <= '0;
         end else if (next_a) begin
            base <= pos[I-1] + pos_t'(1);
            for (int n = 0; n < I; n++) begin
               row_num[n] <= row_d[n];
               col_num[n] <= col_d[n];
            end
         end
      end
   end

endmodule

// File: rtl/pos_divmod.sv
// Linear position -> (row, col) for a square tile of the given side.
// pos  : linear position
// side : tile side length (0 yields row = col = 0)
// quo  : pos / side, truncated to Q_W bits
// rem  : pos % side, truncated to R_W bits
module pos_divmod #(
   parameter int POS_W  = 16,
   parameter int SIDE_W = 6,
   parameter int Q_W    = 6,
   parameter int R_W    = 6
) (
   input  logic [POS_W-1:0]     pos,
   input  logic [SIDE_W-1:0]    side,
   output logic signed [Q_W-1:0] quo,
   output logic signed [R_W-1:0] rem
);

   logic [POS_W-1:0] side_ext;
   assign side_ext = POS_W'(side);

   always_comb begin
      if (side == '0) begin
         quo = '0;
         rem = '0;
      end else begin
         quo = Q_W'(pos / side_ext);
         rem = R_W'(pos % side_ext);
      end
   end

endmodule

// File: rtl/index_decoder.sv
// Sparse index decoder top: input-activation lanes and filter-weight lanes
// decoded side by side from zero-run-length index vectors.
// clk : clock
// rst : synchronous reset, active-high
// bus : index_decoder_if.slave (controls, index vectors, decoded positions)
module index_decoder import index_decoder_pkg::*; (
   input logic           clk,
   input logic           rst,
   index_decoder_if.slave bus
);

   logic filter_restart;
   assign filter_restart = bus.next_a | bus.K_changing | bus.Layer_change_flag;

   index_decoder_input u_input (
      .clk                 (clk),
      .rst                 (rst),
      .stall               (bus.stall),
      .next_a              (bus.next_a),
      .decode_restart      (bus.decode_restart),
      .first_Ex_state_cycle(bus.first_Ex_state_cycle),
      .index_vector        (bus.input_index_vector),
      .side_length         (bus.input_side_length),
      .row_num             (bus.in_row_num),
      .col_num             (bus.in_col_num)
   );

   index_decoder_filter u_filter (
      .clk         (clk),
      .rst         (rst),
      .stall       (bus.stall),
      .restart     (filter_restart),
      .layer_change(bus.Layer_change_flag),
      .index_vector(bus.filter_index_vector),
      .filter_size (bus.each_filter_size),
      .side_length (bus.filter_side_length),
      .row_num     (bus.f_row_num),
      .col_num     (bus.f_col_num),
      .k_num       (bus.k_num),
      .res_rdy     (bus.res_rdy)
   );

endmodule

// File: tb/tb_index_decoder.sv
module tb_index_decoder;
   import index_decoder_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   index_decoder_if bus ();
   index_decoder dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      in_row_t [I-1:0]       in_row;
      in_col_t [I-1:0]       in_col;
      f_row_t  [F-1:0]       f_row;
      f_col_t  [F-1:0]       f_col;
      logic [F-1:0][K_W-1:0] k;
      logic [F-1:0]          rdy;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_out;
   int   m_base, m_fb, m_fk;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   // Reference: positions are running sums of (zeros + 1); the filter stream
   // additionally counts how many filters it has stepped past.
   task automatic model_step();
      int p, k, side, fs, fside;
      bit rs;
      if (rst) begin
         m_out  = '0;
         m_base = 0;
         m_fb   = 0;
         m_fk   = 0;
      end else if (!bus.stall) begin
         if (bus.decode_restart) begin
            m_base = 0;
         end else if (bus.next_a) begin
            side = int'(bus.input_side_length);
            p = bus.first_Ex_state_cycle ? 0 : m_base;
            for (int n = 0; n < I; n++) begin
               p += int'(bus.input_index_vector[n]) + ((n > 0) ? 1 : 0);
               m_out.in_row[n] = (side == 0) ? '0 : in_row_t'(p / side);
               m_out.in_col[n] = (side == 0) ? '0 : in_col_t'(p % side);
            end
            m_base = p + 1;
         end
         rs    = bus.next_a || bus.K_changing || bus.Layer_change_flag;
         fs    = int'(bus.each_filter_size);
         fside = int'(bus.filter_side_length);
         p = rs ? 0 : m_fb;
         k = rs ? 0 : m_fk;
         for (int n = 0; n < F; n++) begin
            p += int'(bus.filter_index_vector[n]) + ((n > 0) ? 1 : 0);
            if (p >= fs) begin
               p -= fs;
               k++;
            end
            m_out.f_row[n] = (fside == 0) ? '0 : f_row_t'(p / fside);
            m_out.f_col[n] = (fside == 0) ? '0 : f_col_t'(p % fside);
            m_out.k[n]     = K_W'((k > KC) ? KC : k);
            m_out.rdy[n]   = (k < KC) && !bus.Layer_change_flag;
         end
         m_fb = rs ? 0 : p + 1;
         m_fk = rs ? 0 : k;
      end
      exp_q.push_back(m_out);
   endtask

   // Inputs are applied at a negedge; this records the expectation and moves
   // to the next negedge, by which time the DUT has registered them.
   task automatic cyc();
      model_step();
      @(negedge clk);
   endtask

   task automatic chk_in(input string tag, input logic [23:0] rows, input logic [23:0] cols);
      check({tag, "_in_row"}, 64'(bus.in_row_num), 64'(rows));
      check({tag, "_in_col"}, 64'(bus.in_col_num), 64'(cols));
   endtask

   task automatic chk_f(input string tag, input logic [19:0] rows, input logic [19:0] cols,
                        input logic [15:0] ks, input logic [3:0] rdy);
      check({tag, "_f_row"}, 64'(bus.f_row_num), 64'(rows));
      check({tag, "_f_col"}, 64'(bus.f_col_num), 64'(cols));
      check({tag, "_k_num"}, 64'(bus.k_num), 64'(ks));
      check({tag, "_res_rdy"}, 64'(bus.res_rdy), 64'(rdy));
   endtask

   task automatic set_fidx(input int a, input int b, input int c, input int d);
      bus.filter_index_vector[0] = IDX_W'(a);
      bus.filter_index_vector[1] = IDX_W'(b);
      bus.filter_index_vector[2] = IDX_W'(c);
      bus.filter_index_vector[3] = IDX_W'(d);
   endtask

   // Monitor: every clock the DUT presents a fresh output set.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_in_row",  64'(bus.in_row_num), 64'(e.in_row));
            check("sb_in_col",  64'(bus.in_col_num), 64'(e.in_col));
            check("sb_f_row",   64'(bus.f_row_num),  64'(e.f_row));
            check("sb_f_col",   64'(bus.f_col_num),  64'(e.f_col));
            check("sb_k_num",   64'(bus.k_num),      64'(e.k));
            check("sb_res_rdy", 64'(bus.res_rdy),    64'(e.rdy));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench still running at %0t, expected finish", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.stall = 0; bus.next_a = 0; bus.decode_restart = 0; bus.first_Ex_state_cycle = 0;
      bus.input_index_vector = '0; bus.input_side_length = 6'd5;
      bus.filter_index_vector = '0; bus.each_filter_size = 8'd9; bus.filter_side_length = 5'd3;
      bus.Layer_change_flag = 0; bus.K_changing = 0;
      @(negedge clk);
      cyc(); cyc();
      chk_in("reset", 24'h0, 24'h0);
      chk_f("reset", 20'h0, 20'h0, 16'h0, 4'h0);
      rst = 1'b0;

      // input stream from a restarted base
      bus.decode_restart = 1; cyc(); bus.decode_restart = 0;
      bus.next_a = 1; cyc();
      chk_in("in_v0", {6'd0, 6'd0, 6'd0, 6'd0}, {6'd3, 6'd2, 6'd1, 6'd0});
      bus.input_index_vector[0] = 4'd1; cyc();
      chk_in("in_v1", {6'd1, 6'd1, 6'd1, 6'd1}, {6'd3, 6'd2, 6'd1, 6'd0});
      bus.next_a = 0; bus.input_index_vector = '0;

      // filter stream with a group wrap
      bus.K_changing = 1; cyc(); bus.K_changing = 0;
      set_fidx(2, 3, 1, 0); cyc();
      chk_f("f_v0", {5'd0, 5'd2, 5'd2, 5'd0}, {5'd0, 5'd2, 5'd0, 5'd2}, {4'd1, 4'd0, 4'd0, 4'd0}, 4'hF);
      set_fidx(0, 0, 0, 0); cyc();
      chk_f("f_v1", {5'd1, 5'd1, 5'd0, 5'd0}, {5'd1, 5'd0, 5'd2, 5'd1}, {4'd1, 4'd1, 4'd1, 4'd1}, 4'hF);

      // stall freezes everything, including pending controls
      bus.stall = 1; bus.next_a = 1; bus.K_changing = 1; bus.decode_restart = 1;
      repeat (3) cyc();
      chk_f("stall", {5'd1, 5'd1, 5'd0, 5'd0}, {5'd1, 5'd0, 5'd2, 5'd1}, {4'd1, 4'd1, 4'd1, 4'd1}, 4'hF);
      chk_in("stall", {6'd1, 6'd1, 6'd1, 6'd1}, {6'd3, 6'd2, 6'd1, 6'd0});
      bus.stall = 0; bus.next_a = 0; bus.K_changing = 0; bus.decode_restart = 0;
      cyc();
      chk_f("resume", {5'd2, 5'd2, 5'd2, 5'd1}, {5'd2, 5'd1, 5'd0, 5'd2}, {4'd1, 4'd1, 4'd1, 4'd1}, 4'hF);

      // decode_restart holds outputs, then the next vector starts at 0
      bus.next_a = 1; bus.input_index_vector[0] = 4'd1; cyc();
      chk_in("in_v2", {6'd2, 6'd2, 6'd2, 6'd2}, {6'd3, 6'd2, 6'd1, 6'd0});
      bus.next_a = 0; bus.decode_restart = 1; bus.input_index_vector = '0; cyc();
      chk_in("dec_restart", {6'd2, 6'd2, 6'd2, 6'd2}, {6'd3, 6'd2, 6'd1, 6'd0});
      bus.decode_restart = 0; bus.next_a = 1; cyc();
      chk_in("in_after_restart", 24'h0, {6'd3, 6'd2, 6'd1, 6'd0});
      bus.next_a = 0;
      bus.K_changing = 1; cyc(); bus.K_changing = 0;
      chk_f("k_change", {5'd1, 5'd0, 5'd0, 5'd0}, {5'd0, 5'd2, 5'd1, 5'd0}, 16'h0, 4'hF);

      // layer change, then run k past the group end
      bus.Layer_change_flag = 1; cyc(); bus.Layer_change_flag = 0;
      check("layer_res_rdy", 64'(bus.res_rdy), 64'h0);
      bus.each_filter_size = 8'd1; bus.filter_side_length = 5'd1;
      cyc();
      chk_f("k_run_a", 20'h0, 20'h0, {4'd3, 4'd2, 4'd1, 4'd0}, 4'hF);
      cyc();
      chk_f("k_run_b", 20'h0, 20'h0, {4'd7, 4'd6, 4'd5, 4'd4}, 4'hF);
      cyc();
      chk_f("k_sat", 20'h0, 20'h0, {4'd8, 4'd8, 4'd8, 4'd8}, 4'h0);
      bus.each_filter_size = 8'd9; bus.filter_side_length = 5'd3;

      // reset mid-stream
      bus.next_a = 1; cyc(); bus.next_a = 0;
      rst = 1; cyc(); rst = 0;
      chk_in("rst_mid", 24'h0, 24'h0);
      chk_f("rst_mid", 20'h0, 20'h0, 16'h0, 4'h0);

      // randomized traffic against the reference model
      for (int t = 0; t < 300; t++) begin
         int fside;
         rst                      = ($urandom_range(0, 49) == 0);
         bus.stall                = ($urandom_range(0, 5) == 0);
         bus.next_a               = ($urandom_range(0, 2) == 0);
         bus.decode_restart       = ($urandom_range(0, 9) == 0);
         bus.first_Ex_state_cycle = ($urandom_range(0, 4) == 0);
         bus.K_changing           = ($urandom_range(0, 9) == 0);
         bus.Layer_change_flag    = ($urandom_range(0, 14) == 0);
         for (int n = 0; n < I; n++) bus.input_index_vector[n] = IDX_W'($urandom_range(0, MAX_INDEX - 1));
         for (int n = 0; n < F; n++) bus.filter_index_vector[n] = IDX_W'($urandom_range(0, MAX_INDEX - 1));
         bus.input_side_length  = IN_SIDE_W'($urandom_range(1, MAX_NUM_HT));
         fside                  = $urandom_range(1, MAX_SIZE_R);
         bus.filter_side_length = F_SIDE_W'(fside);
         bus.each_filter_size   = F_SIZE_W'($urandom_range(1, fside * fside));
         cyc();
      end
      rst = 0; bus.stall = 1;
      for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
